// File: rtl/trap_scheduler.sv
// Frame-rate trap sequencer. Each slot runs IDLE/ARMED/PENDING/RUN/DONE. Slots are granted
// run places under a concurrency limit. A global PLAY/DEAD/RESPAWN loop freezes and re-arms the slots.

module trap_slot #(
  parameter int CNT_W = 6
) (
  input  logic             frame_clk,
  input  logic             Reset_n,
  input  logic [9:0]       kid_x,
  input  logic [9:0]       kid_y,
  input  logic             wr,
  input  logic [9:0]       wr_xmin,
  input  logic [9:0]       wr_xmax,
  input  logic [9:0]       wr_ymin,
  input  logic [CNT_W-1:0] wr_frames,
  input  logic             act,
  input  logic             grant,
  input  logic             rearm,
  output logic             pending,
  output logic             run,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_PENDING, S_RUN, S_DONE} slot_state_e;

  slot_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_d, frames;
  logic [9:0]       xmin, xmax, ymin;
  logic             in_zone;

  assign in_zone = (kid_x > xmin) && (kid_x < xmax) && (kid_y > ymin);

  // Config write beats everything; act is PLAY without a same-edge hit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt;
    if (wr) begin
      state_d = S_ARMED;
      cnt_d   = '0;
    end else if (rearm) begin
      if (state_q != S_IDLE) begin
        state_d = S_ARMED;
        cnt_d   = '0;
      end
    end else if (act) begin
      case (state_q)
        S_ARMED:   if (in_zone) state_d = S_PENDING;
        S_PENDING: if (grant) state_d = S_RUN;
        S_RUN: begin
          // frames==0 wraps to all-ones, giving a 2^CNT_W run
          if (cnt == frames - CNT_W'(1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt     <= '0;
      xmin    <= '0;
      xmax    <= '0;
      ymin    <= '0;
      frames  <= '0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
      if (wr) begin
        xmin   <= wr_xmin;
        xmax   <= wr_xmax;
        ymin   <= wr_ymin;
        frames <= wr_frames;
      end
    end
  end

  assign pending = (state_q == S_PENDING);
  assign run     = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

endmodule

module trap_scheduler #(
  parameter int NUM_TRAPS  = 4,
  parameter int MAX_ACTIVE = 2,
  parameter int CNT_W      = 6
) (
  input  logic                       frame_clk,
  input  logic                       Reset_n,
  input  logic [9:0]                 Kid_position_X,
  input  logic [9:0]                 Kid_position_Y,
  input  logic                       hit_in,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_idx,
  input  logic [9:0]                 cfg_xmin,
  input  logic [9:0]                 cfg_xmax,
  input  logic [9:0]                 cfg_ymin,
  input  logic [CNT_W-1:0]           cfg_frames,
  input  logic                       respawn_req,
  output logic [NUM_TRAPS-1:0]       step,
  output logic [NUM_TRAPS-1:0]       trap_run,
  output logic [NUM_TRAPS-1:0]       trap_done,
  output logic [NUM_TRAPS*CNT_W-1:0] trap_frame,
  output logic                       dead,
  output logic                       respawn_ack
);

  typedef enum logic [1:0] {G_PLAY, G_DEAD, G_RESPAWN} glob_state_e;

  localparam logic [3:0] MAX_A = 4'(MAX_ACTIVE);

  glob_state_e                     g_q, g_d;
  logic                            play, act, rearm;
  logic [NUM_TRAPS-1:0]            wr_sel, pending, run, grant;
  logic [NUM_TRAPS-1:0][CNT_W-1:0] cnt;
  logic [3:0]                      run_cnt, free, given;

  always_comb begin
    g_d = g_q;
    case (g_q)
      G_PLAY:    if (hit_in) g_d = G_DEAD;
      G_DEAD:    if (respawn_req) g_d = G_RESPAWN;
      G_RESPAWN: g_d = G_PLAY;
      default:   g_d = G_PLAY;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) g_q <= G_PLAY;
    else          g_q <= g_d;
  end

  assign play  = (g_q == G_PLAY);
  assign act   = play && !hit_in;
  assign rearm = (g_q == G_RESPAWN);

  // Places are counted from pre-edge RUN slots, so a slot finishing this edge frees nothing until the next.
  always_comb begin
    run_cnt = '0;
    given   = '0;
    grant   = '0;
    for (int i = 0; i < NUM_TRAPS; i++) run_cnt = run_cnt + 4'(run[i]);
    free = MAX_A - run_cnt;
    for (int i = 0; i < NUM_TRAPS; i++) begin
      if (pending[i] && (given < free)) begin
        grant[i] = 1'b1;
        given    = given + 4'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_TRAPS; i++) begin : g_slot
    assign wr_sel[i] = cfg_we && (cfg_idx == 3'(i));
    trap_slot #(.CNT_W(CNT_W)) u_slot (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .kid_x     (Kid_position_X),
      .kid_y     (Kid_position_Y),
      .wr        (wr_sel[i]),
      .wr_xmin   (cfg_xmin),
      .wr_xmax   (cfg_xmax),
      .wr_ymin   (cfg_ymin),
      .wr_frames (cfg_frames),
      .act       (act),
      .grant     (grant[i]),
      .rearm     (rearm),
      .pending   (pending[i]),
      .run       (run[i]),
      .done      (trap_done[i]),
      .cnt       (cnt[i])
    );
  end

  assign step        = run & {NUM_TRAPS{play}};
  assign trap_run    = run;
  assign trap_frame  = cnt;
  assign dead        = (g_q == G_DEAD);
  assign respawn_ack = rearm;

endmodule

// File: tb/tb_trap_scheduler.sv
// Directed bench for trap_scheduler: expected output snapshots are queued per step and
// popped and compared once the edge has been taken.

module tb_trap_scheduler;

  logic        frame_clk, Reset_n;
  logic [9:0]  Kid_position_X, Kid_position_Y;
  logic        hit_in, cfg_we, respawn_req;
  logic [2:0]  cfg_idx;
  logic [9:0]  cfg_xmin, cfg_xmax, cfg_ymin;
  logic [5:0]  cfg_frames;
  logic [3:0]  step, trap_run, trap_done;
  logic [23:0] trap_frame;
  logic        dead, respawn_ack;
  logic [37:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct { string tag; logic [37:0] val; } exp_t;
  exp_t sb[$];

  trap_scheduler #(.NUM_TRAPS(4), .MAX_ACTIVE(2), .CNT_W(6)) dut (
    .frame_clk      (frame_clk),
    .Reset_n        (Reset_n),
    .Kid_position_X (Kid_position_X),
    .Kid_position_Y (Kid_position_Y),
    .hit_in         (hit_in),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_xmin       (cfg_xmin),
    .cfg_xmax       (cfg_xmax),
    .cfg_ymin       (cfg_ymin),
    .cfg_frames     (cfg_frames),
    .respawn_req    (respawn_req),
    .step           (step),
    .trap_run       (trap_run),
    .trap_done      (trap_done),
    .trap_frame     (trap_frame),
    .dead           (dead),
    .respawn_ack    (respawn_ack)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  assign obs = {trap_run, trap_done, step, trap_frame, dead, respawn_ack};

  function automatic logic [23:0] fr(int s, int v);
    logic [23:0] f;
    f = '0;
    f[s*6 +: 6] = 6'(v);
    return f;
  endfunction

  function automatic logic [37:0] ex(logic [3:0] r, logic [3:0] d, logic [3:0] s,
                                     logic [23:0] f, logic dd, logic a);
    return {r, d, s, f, dd, a};
  endfunction

  task automatic push_exp(string tag, logic [37:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_now(string tag, logic [37:0] v);
    push_exp(tag, v);
    check_front();
  endtask

  task automatic step_chk(string tag, logic [37:0] v);
    push_exp(tag, v);
    @(posedge frame_clk);
    #1;
    check_front();
  endtask

  task automatic do_cfg(int idx, int frames, string tag, logic [37:0] v);
    cfg_idx    = 3'(idx);
    cfg_xmin   = 10'd392;
    cfg_xmax   = 10'd408;
    cfg_ymin   = 10'd138;
    cfg_frames = 6'(frames);
    cfg_we     = 1'b1;
    step_chk(tag, v);
    cfg_we     = 1'b0;
  endtask

  task automatic kid(int x, int y);
    Kid_position_X = 10'(x);
    Kid_position_Y = 10'(y);
  endtask

  initial begin
    Reset_n = 1'b0; hit_in = 1'b0; cfg_we = 1'b0; respawn_req = 1'b0;
    cfg_idx = '0; cfg_xmin = '0; cfg_xmax = '0; cfg_ymin = '0; cfg_frames = '0;
    kid(400, 150);
    #3;
    chk_now("reset_state", '0);
    @(posedge frame_clk); #1;
    Reset_n = 1'b1;

    // single trap: trigger, 1-frame latency, 15-frame run, done
    do_cfg(0, 15, "t1_cfg", '0);
    step_chk("t1_pending", '0);
    for (int i = 0; i < 15; i++)
      step_chk($sformatf("t1_run_f%0d", i), ex(4'b0001, 4'b0, 4'b0001, fr(0, i), 1'b0, 1'b0));
    step_chk("t1_done", ex(4'b0, 4'b0001, 4'b0, '0, 1'b0, 1'b0));
    step_chk("t1_done_hold", ex(4'b0, 4'b0001, 4'b0, '0, 1'b0, 1'b0));

    // concurrency limit: three slots triggered together, two places
    Reset_n = 1'b0;
    step_chk("t2_reset", '0);
    Reset_n = 1'b1;
    kid(0, 0);
    do_cfg(0, 4, "t2_cfg0", '0);
    do_cfg(1, 4, "t2_cfg1", '0);
    do_cfg(2, 4, "t2_cfg2", '0);
    kid(400, 150);
    step_chk("t2_pending", '0);
    for (int k = 0; k < 4; k++)
      step_chk($sformatf("t2_run01_f%0d", k),
               ex(4'b0011, 4'b0, 4'b0011, fr(0, k) | fr(1, k), 1'b0, 1'b0));
    step_chk("t2_done01_s2_wait", ex(4'b0, 4'b0011, 4'b0, '0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++)
      step_chk($sformatf("t2_run2_f%0d", k),
               ex(4'b0100, 4'b0011, 4'b0100, fr(2, k), 1'b0, 1'b0));
    step_chk("t2_all_done", ex(4'b0, 4'b0111, 4'b0, '0, 1'b0, 1'b0));

    // death freezes a running trap, respawn re-arms it
    Reset_n = 1'b0;
    step_chk("t3_reset", '0);
    Reset_n = 1'b1;
    do_cfg(0, 15, "t3_cfg", '0);
    step_chk("t3_pending", '0);
    for (int i = 0; i < 6; i++)
      step_chk($sformatf("t3_run_f%0d", i), ex(4'b0001, 4'b0, 4'b0001, fr(0, i), 1'b0, 1'b0));
    hit_in = 1'b1;
    step_chk("t3_dead", ex(4'b0001, 4'b0, 4'b0, fr(0, 5), 1'b1, 1'b0));
    hit_in = 1'b0;
    step_chk("t3_dead_hold", ex(4'b0001, 4'b0, 4'b0, fr(0, 5), 1'b1, 1'b0));
    respawn_req = 1'b1;
    step_chk("t3_respawn_ack", ex(4'b0001, 4'b0, 4'b0, fr(0, 5), 1'b0, 1'b1));
    respawn_req = 1'b0;
    step_chk("t3_rearmed", '0);
    step_chk("t3_no_exit_trigger", '0);
    step_chk("t3_rerun_f0", ex(4'b0001, 4'b0, 4'b0001, '0, 1'b0, 1'b0));

    // asynchronous reset mid-run, slots stay idle with kid in zone
    #2;
    Reset_n = 1'b0;
    #1;
    chk_now("t4_async_reset", '0);
    step_chk("t4_reset_edge", '0);
    Reset_n = 1'b1;
    step_chk("t4_idle_1", '0);
    step_chk("t4_idle_2", '0);

    // zero length wraps to a 64-frame run
    do_cfg(1, 0, "t5_cfg", '0);
    step_chk("t5_pending", '0);
    for (int i = 0; i < 64; i++)
      step_chk($sformatf("t5_run_f%0d", i), ex(4'b0010, 4'b0, 4'b0010, fr(1, i), 1'b0, 1'b0));
    step_chk("t5_done", ex(4'b0, 4'b0010, 4'b0, '0, 1'b0, 1'b0));

    // out-of-range index ignored; config write into a running slot re-arms it
    do_cfg(0, 15, "t6_cfg", ex(4'b0, 4'b0010, 4'b0, '0, 1'b0, 1'b0));
    step_chk("t6_pending", ex(4'b0, 4'b0010, 4'b0, '0, 1'b0, 1'b0));
    step_chk("t6_run_f0", ex(4'b0001, 4'b0010, 4'b0001, '0, 1'b0, 1'b0));
    do_cfg(5, 3, "t6_idx5_ignored", ex(4'b0001, 4'b0010, 4'b0001, fr(0, 1), 1'b0, 1'b0));
    do_cfg(0, 15, "t6_cfg_in_run", ex(4'b0, 4'b0010, 4'b0, '0, 1'b0, 1'b0));
    step_chk("t6_repending", ex(4'b0, 4'b0010, 4'b0, '0, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
